// File: rtl/winner_pkg.sv
// rtl/winner_pkg.sv - shared encodings and FSM state type for the winner scanner
package winner_pkg;

    localparam logic [1:0] GS_NONE = 2'b00;
    localparam logic [1:0] GS_P1   = 2'b01;
    localparam logic [1:0] GS_P2   = 2'b10;
    localparam logic [1:0] GS_DRAW = 2'b11;

    localparam logic [1:0] DIR_H  = 2'd0;
    localparam logic [1:0] DIR_V  = 2'd1;
    localparam logic [1:0] DIR_UR = 2'd2;
    localparam logic [1:0] DIR_UL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/winner_window_check.sv
// rtl/winner_window_check.sv - combinational test of one anchor/direction line window
module winner_window_check
    import winner_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIN_LEN = 4,
    localparam int N      = ROWS * COLS,
    localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  board,
    input  logic [N-1:0]  player,
    input  logic [AW-1:0] anchor,
    input  logic [1:0]    dir,
    output logic          win,
    output logic          owner
);

    always_comb begin
        int   r0, c0, dr, dc, r_end, c_end, idx;
        logic fits, ok;
        r0 = int'(anchor) / COLS;
        c0 = int'(anchor) % COLS;
        dr = 0;
        dc = 1;
        case (dir)
            DIR_H:   begin dr = 0; dc = 1;  end
            DIR_V:   begin dr = 1; dc = 0;  end
            DIR_UR:  begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        r_end = r0 + (WIN_LEN - 1) * dr;
        c_end = c0 + (WIN_LEN - 1) * dc;
        fits  = (r_end < ROWS) && (c_end >= 0) && (c_end < COLS);
        owner = player[anchor];
        ok    = fits;
        // Owner bits are only compared once the cell is known occupied
        for (int i = 0; i < WIN_LEN; i++) begin
            idx = (r0 + i * dr) * COLS + c0 + i * dc;
            if (fits) begin
                if (!board[AW'(idx)] || (player[AW'(idx)] != owner)) begin
                    ok = 1'b0;
                end
            end
        end
        win = ok;
    end

endmodule

// File: rtl/winner_scanner.sv
// rtl/winner_scanner.sv - sequential scan of all line candidates on a board snapshot
module winner_scanner
    import winner_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIN_LEN = 4,
    localparam int N      = ROWS * COLS,
    localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  game_board,
    input  logic [N-1:0]  player_cells,
    output logic          busy,
    output logic          done,
    output logic [1:0]    game_status,
    output logic [AW-1:0] win_anchor,
    output logic [1:0]    win_dir
);

    localparam int             CW      = AW + 2;
    localparam logic [CW-1:0]  LAST_K  = CW'(4 * N - 1);
    localparam int             MAX_DIM = (ROWS > COLS) ? ROWS : COLS;

    if (WIN_LEN < 2 || WIN_LEN > MAX_DIM) begin : g_bad_win_len
        $error("winner_scanner: WIN_LEN must lie in [2, max(ROWS,COLS)]");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  board_q, board_d;
    logic [N-1:0]  player_q, player_d;
    logic [1:0]    status_q, status_d;
    logic [AW-1:0] anchor_q, anchor_d;
    logic [1:0]    dir_q, dir_d;

    logic cand_win, cand_owner;

    winner_window_check #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) u_window (
        .board  (board_q),
        .player (player_q),
        .anchor (cnt_q[CW-1:2]),
        .dir    (cnt_q[1:0]),
        .win    (cand_win),
        .owner  (cand_owner)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        board_d  = board_q;
        player_d = player_q;
        status_d = status_q;
        anchor_d = anchor_q;
        dir_d    = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    board_d  = game_board;
                    player_d = player_cells;
                    cnt_d    = '0;
                    status_d = GS_NONE;
                    anchor_d = '0;
                    dir_d    = DIR_H;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cand_win) begin
                    status_d = cand_owner ? GS_P2 : GS_P1;
                    anchor_d = cnt_q[CW-1:2];
                    dir_d    = cnt_q[1:0];
                    state_d  = ST_DONE;
                end else if (cnt_q == LAST_K) begin
                    status_d = (&board_q) ? GS_DRAW : GS_NONE;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            board_q  <= '0;
            player_q <= '0;
            status_q <= GS_NONE;
            anchor_q <= '0;
            dir_q    <= DIR_H;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            board_q  <= board_d;
            player_q <= player_d;
            status_q <= status_d;
            anchor_q <= anchor_d;
            dir_q    <= dir_d;
        end
    end

    assign busy        = (state_q == ST_SCAN);
    assign done        = (state_q == ST_DONE);
    assign game_status = status_q;
    assign win_anchor  = anchor_q;
    assign win_dir     = dir_q;

endmodule

// File: tb/tb_winner_scanner.sv
// tb/tb_winner_scanner.sv - directed self-checking bench for winner_scanner
module tb_winner_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] game_board;
    logic [15:0] player_cells;
    logic        busy;
    logic        done;
    logic [1:0]  game_status;
    logic [3:0]  win_anchor;
    logic [1:0]  win_dir;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    winner_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .game_board   (game_board),
        .player_cells (player_cells),
        .busy         (busy),
        .done         (done),
        .game_status  (game_status),
        .win_anchor   (win_anchor),
        .win_dir      (win_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a scan in the current cycle N and wait for done; extra_at re-pulses
    // start and rewrites the board inputs in cycle N+extra_at
    task automatic run_scan(input string tag, input logic [15:0] brd, input logic [15:0] ply,
                            input logic [1:0] es, input int ea, input int ed, input int el,
                            input int extra_at, input logic [15:0] mid_brd);
        int  n;
        bit  seen;
        @(negedge clk);
        game_board   = brd;
        player_cells = ply;
        start        = 1'b1;
        n            = cyc;
        seen         = 1'b0;
        for (int t = 1; t <= 200 && !seen; t++) begin
            @(negedge clk);
            start = (extra_at != 0 && t == extra_at);
            if (extra_at != 0 && t == extra_at) begin
                game_board   = mid_brd;
                player_cells = ~ply;
            end
            if (t == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                chk({tag, "_lat"}, 32'(cyc - n), 32'(el));
                chk({tag, "_status"}, 32'(game_status), 32'(es));
                chk({tag, "_anchor"}, 32'(win_anchor), 32'(ea));
                chk({tag, "_dir"}, 32'(win_dir), 32'(ed));
                chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            end
        end
        start = 1'b0;
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        reset        = 1'b1;
        start        = 1'b0;
        game_board   = '0;
        player_cells = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(game_status), 32'd0);
        chk("rst_anchor", 32'(win_anchor), 32'd0);
        chk("rst_dir", 32'(win_dir), 32'd0);
        reset = 1'b0;

        // P1 row 0, P2 on cells 4-6: candidate 0 wins
        run_scan("p1_row0", 16'h007F, 16'h0070, 2'b01, 0, 0, 2, 0, 16'h0);
        repeat (4) @(negedge clk);
        chk("hold_status", 32'(game_status), 32'd1);

        // P2 column 1 with scattered P1 and junk owner bit at empty cell 8
        run_scan("p2_col1", 16'hAA63, 16'h2322, 2'b10, 1, 1, 7, 0, 16'h0);

        // P1 up-left diagonal from cell 3, junk owner bits on empty cells
        run_scan("p1_diag", 16'h1248, 16'hE000, 2'b01, 3, 3, 17, 0, 16'h0);
        repeat (3) @(negedge clk);
        chk("hold_anchor", 32'(win_anchor), 32'd3);
        chk("hold_dir", 32'(win_dir), 32'd3);

        // Full board without a line: draw after all 64 candidates
        run_scan("draw", 16'hFFFF, 16'h3C3C, 2'b11, 0, 0, 65, 0, 16'h0);

        // Partial board, extra start and board change at N+10 are ignored
        d0 = done_cnt;
        run_scan("nowin", 16'hFFFE, 16'h3C3C, 2'b00, 0, 0, 65, 10, 16'h000F);
        repeat (3) @(negedge clk);
        chk("nowin_one_done", 32'(done_cnt - d0), 32'd1);

        // Reset in cycle N+20 of a no-win scan aborts it silently
        @(negedge clk);
        game_board   = 16'hFFFE;
        player_cells = 16'h3C3C;
        start        = 1'b1;
        n            = cyc;
        d0           = done_cnt;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == 20) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        chk("abort_cycle", 32'(cyc - n), 32'd21);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_status", 32'(game_status), 32'd0);
        repeat (80) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/winner_scanner.md
WINNER_SCANNER -- requirements
Module: winner_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of board rows; row 0 is the bottom row.
REQ-002 Parameter COLS, default 4, number of board columns.
REQ-003 Parameter WIN_LEN, default 4, number of same-owner cells in a line needed to win.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a scan of the current board; sampled only in IDLE.
REQ-007 game_board  input  ROWS*COLS  occupancy; bit index is row*COLS+col, and 1 means occupied.
REQ-008 player_cells  input  ROWS*COLS  owner of each cell; 0 means P1, 1 means P2; meaningful only where game_board is 1.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 game_status  output  2  result: 00 no result, 01 P1 wins, 10 P2 wins, 11 draw.
REQ-012 win_anchor  output  clog2(ROWS*COLS)  cell index of the first cell of the winning line; 0 if there is no win.
REQ-013 win_dir  output  2  direction of the winning line; 0 if there is no win.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-015 In IDLE, start=1 SHALL snapshot game_board and player_cells, clear the candidate counter, and enter SCAN on the next cycle.
REQ-016 Directions SHALL be encoded as: 0 = +col (horizontal), 1 = +row (vertical), 2 = +row+col (diagonal up-right), 3 = +row-col (diagonal up-left).
REQ-017 Candidate k SHALL map to anchor = k/4 and dir = k%4; there are 4*ROWS*COLS candidates in ascending order.
REQ-018 One candidate SHALL be evaluated per SCAN cycle, using only the snapshot.
REQ-019 A candidate whose WIN_LEN cells do not all fit on the board SHALL be treated as non-winning.
REQ-020 A candidate SHALL win when all WIN_LEN cells are occupied and all have the same owner.
REQ-021 On the first winning candidate, the block SHALL latch the owner (game_status 01 or 10), win_anchor and win_dir, and enter DONE without evaluating further candidates.
REQ-022 If the last candidate is evaluated with no win, game_status SHALL be 11 when every snapshot game_board bit is 1, otherwise 00; the block then enters DONE.
REQ-023 Latency: with start sampled in cycle N and the deciding candidate k, done SHALL be high in cycle N+2+k. With no win, done SHALL be high in cycle N+1+4*ROWS*COLS.
REQ-024 DONE SHALL last one cycle: done=1 and busy=0, then the FSM returns to IDLE.
REQ-025 game_status, win_anchor and win_dir SHALL hold their values until the next accepted start.
REQ-026 Accepting a start SHALL clear game_status to 00.
REQ-027 busy SHALL be 1 in SCAN and 0 in every other state.
REQ-028 start SHALL be ignored while in SCAN or DONE.
REQ-029 Changes to the board inputs during SCAN SHALL have no effect on the current scan.
REQ-030 player_cells bits at unoccupied cells SHALL be ignored.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, game_status=00, win_anchor=0, win_dir=0, and counter=0.
REQ-032 reset SHALL take priority over start and over any in-progress scan.
REQ-033 After a mid-scan reset, no done pulse SHALL be produced for the aborted scan.

Structure
REQ-034 A shared package winner_pkg SHALL hold the game_status encodings, the direction encodings and the FSM state type.
REQ-035 The combinational window test SHALL be a sub-module winner_window_check (inputs: snapshot, anchor, dir; outputs: win, owner).
REQ-036 Elaboration SHALL fail unless 2 <= WIN_LEN <= max(ROWS,COLS).

Verification (defaults 4x4, WIN_LEN=4, start sampled in cycle N)
REQ-037 P1 owns cells 0-3, with P2 on cells 4-6 -> game_status=01, win_anchor=0, win_dir=0, done in cycle N+2.
REQ-038 P2 owns cells 1,5,9,13, with P1 scattered elsewhere -> game_status=10, win_anchor=1, win_dir=1, done in cycle N+7.
REQ-039 Full board with player_cells=16'h3C3C -> game_status=11, done in cycle N+65.
REQ-040 Partial board with no line -> game_status=00 and done in cycle N+65; a start pulse at N+10 is ignored, and only one done pulse occurs.
REQ-041 Reset asserted at N+20 during a no-win scan -> busy=0 and game_status=00 from N+21, and no done pulse occurs.
REQ-042 P1 owns cells 3,6,9,12 -> game_status=01, win_anchor=3, win_dir=3, done in cycle N+17.
